key_debounce: RTL and testbench
===============================

# key_debounce

Debounces one raw push-button input using the slow square wave from the upstream clock divider as its sample timebase. It sits directly downstream of the divider: it consumes the divider's toggling output and produces a clean key level plus one-cycle press/release pulses for the application logic. An optional auto-repeat generator re-issues press pulses while the key is held.

## Interface
- `STABLE_SAMPLES`, default 4: consecutive agreeing samples needed to accept a level change; legal range 2..15.
- `REPEAT_DELAY`, default 8: strobes from accepted press to first repeat; used only with auto-repeat.
- `REPEAT_RATE`, default 2: strobes between subsequent repeats; used only with auto-repeat.
- `clk`  input  1  system clock; also clocks the upstream divider.
- `rst`  input  1  synchronous, active-high reset.
- `tick_in`  input  1  divider output square wave; each rising edge is one sample strobe.
- `key_n`  input  1  raw button, active-low, asynchronous, bouncy.
- `key_level`  output  1  debounced level, 1 = pressed.
- `press`  output  1  one-cycle pulse per accepted press, including repeats.
- `release`  output  1  one-cycle pulse per accepted release.
- `press_count`  output  8  running count of `press` pulses.

## Operation
- `key_n` passes through a 2-flop synchronizer. Both flops reset to 1, which is the released state. The sample is `pressed_s = ~sync2`.
- `tick_q` registers `tick_in`. The strobe is `tick_in & ~tick_q`. `tick_q` resets to 1, so a high `tick_in` at reset release does not produce a strobe.
- FSM states are IDLE, PRESS_WAIT, PRESSED, and RELEASE_WAIT. The 4-bit sample counter `cnt` advances only on strobe cycles.
  - IDLE: on a strobe with `pressed_s=1`, go to PRESS_WAIT with `cnt=1`.
  - PRESS_WAIT: on a strobe with `pressed_s=1`, `cnt++`. When `cnt` reaches `STABLE_SAMPLES`, go to PRESSED, set `key_level=1`, and pulse `press`. On a strobe with `pressed_s=0`, return to IDLE with `cnt=0`.
  - PRESSED: on a strobe with `pressed_s=0`, go to RELEASE_WAIT with `cnt=1`.
  - RELEASE_WAIT: mirror of PRESS_WAIT. When the count completes, go to IDLE, set `key_level=0`, and pulse `release`. On a strobe with `pressed_s=1`, return to PRESSED with no pulse.
- Samples between strobes are ignored.
- `press_count` increments by one on every `press` pulse and wraps from 255 to 0.
- Reset values: all outputs 0, state IDLE, `cnt=0`, repeat counter 0. A reset asserted mid-operation discards any in-progress count and produces no `release` pulse.

## Timing
- Outputs are registered. `press`, `release`, and the `key_level` change all appear in the cycle after the clock edge that samples the completing strobe.
- `press_count` updates in the same cycle that `press` is high.
- `key_n` reaches `pressed_s` 2 cycles after a change.
- Minimum acceptance time from a clean edge to a pulse is `STABLE_SAMPLES` strobes, plus up to 1 strobe period of alignment, plus 3 cycles.
- `press` and `release` never assert in the same cycle. Each pulse lasts exactly 1 cycle.
- Between strobes the FSM holds its state and `cnt`.

## Configuration
- Macro: `KEY_DEBOUNCE_AUTOREPEAT_EN`.
- Defined:
  - In PRESSED, a repeat counter clears on the accepted press and increments on each strobe where `pressed_s=1`.
  - When it reaches `REPEAT_DELAY`, `press` pulses, `press_count` increments, and the counter reloads to 0 with `REPEAT_RATE` as the new threshold.
  - The counter and threshold reset on leaving PRESSED.
  - A strobe sampled as released stops repeats immediately, including during RELEASE_WAIT.
- Undefined: no repeat logic is present, and PRESSED produces no pulses.

## Test plan
- Test conditions: defaults, with a strobe every 16 clk.
- Clean press: `key_n` 1→0 and held. Required: exactly one `press` after the 4th strobe sample, `key_level` goes to 1, `press_count` goes 0→1, and there is no `release`.
- Bounce:
  - Stimulus: `key_n` toggles so that samples read 1,1,0,1,1,1,1.
  - Required: `press` fires only on the 7th strobe sample, and exactly once.
- Release glitch:
  - Stimulus: while pressed, samples read 0,0,1.
  - Required: return to PRESSED with no `release` and `key_level` held at 1.
  - Stimulus: then 4 released samples.
  - Required: one `release`, and `key_level` goes to 0.
- Wrap: 256 clean press/release cycles. Required: `press_count` returns to 0 and 256 `press` pulses are counted.
- Reset mid-count: assert `rst` for 1 cycle during PRESS_WAIT with `cnt=3`. Required: all outputs are 0 the next cycle, and a fresh 4 samples are needed before `press`.
- Auto-repeat (macro defined): hold the key for 16 strobes after acceptance. Required: repeats at +8, +10, +12, +14, +16 strobes, and `press_count`=6. With the macro undefined: `press_count`=1.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: strobe-sampled push-button debouncer with press/release pulses.
// Optional auto-repeat of press pulses when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
`timescale 1ns/1ps

module key_debounce #(
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned REPEAT_DELAY   = 8,
    parameter int unsigned REPEAT_RATE    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       key_n,
    output logic       key_level,
    output logic       press,
    output logic       release_pulse,
    output logic [7:0] press_count
);

    if (STABLE_SAMPLES < 2 || STABLE_SAMPLES > 15 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("key_debounce: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_e;

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_SAMPLES);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       tick_q, tick_d;
    logic       pressed_s;
    logic       strobe;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept_press;
    logic       accept_release;
    logic       repeat_hit;

    logic       key_level_q, key_level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;
    logic [7:0] press_count_q, press_count_d;

    // Synchronizer and strobe edge detector idle in the released / high state.
    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        tick_d  = tick_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            tick_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            tick_q  <= tick_d;
        end
    end

    assign pressed_s = ~sync2_q;
    assign strobe    = tick_in & ~tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            key_level_q   <= 1'b0;
            press_q       <= 1'b0;
            release_q     <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_level_q   <= key_level_d;
            press_q       <= press_d;
            release_q     <= release_d;
            press_count_q <= press_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        accept_press   = 1'b0;
        accept_release = 1'b0;
        if (strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (pressed_s) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q + 4'd1 == STABLE_CNT) begin
                        state_d      = PRESSED;
                        cnt_d        = '0;
                        accept_press = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                PRESSED: begin
                    if (!pressed_s) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_s) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q + 4'd1 == STABLE_CNT) begin
                        state_d        = IDLE;
                        cnt_d          = '0;
                        accept_release = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned REP_MAX =
        (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_CNT = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] RATE_CNT  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_fast_q, rep_fast_d;
    logic [REP_W-1:0] rep_thresh;

    assign rep_thresh = rep_fast_q ? RATE_CNT : DELAY_CNT;

    // Counter only lives while the FSM stays in PRESSED across this edge.
    always_comb begin
        rep_cnt_d  = rep_cnt_q;
        rep_fast_d = rep_fast_q;
        repeat_hit = 1'b0;
        if (state_q != PRESSED || state_d != PRESSED) begin
            rep_cnt_d  = '0;
            rep_fast_d = 1'b0;
        end else if (strobe && pressed_s) begin
            if (rep_cnt_q + REP_W'(1) == rep_thresh) begin
                repeat_hit = 1'b1;
                rep_cnt_d  = '0;
                rep_fast_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q  <= '0;
            rep_fast_q <= 1'b0;
        end else begin
            rep_cnt_q  <= rep_cnt_d;
            rep_fast_q <= rep_fast_d;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_comb begin
        press_d     = accept_press | repeat_hit;
        release_d   = accept_release;
        key_level_d = key_level_q;
        if (accept_press) begin
            key_level_d = 1'b1;
        end
        if (accept_release) begin
            key_level_d = 1'b0;
        end
        press_count_d = press_count_q + {7'd0, press_d};
    end

    assign key_level     = key_level_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign press_count   = press_count_q;

    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(press && release_pulse));
    a_press_pulse: assert property (@(posedge clk) disable iff (rst)
        press |=> !press);
    a_release_pulse: assert property (@(posedge clk) disable iff (rst)
        release_pulse |=> !release_pulse);

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: strobe-level vector table, directed corner cases,
// and a random phase checked every cycle against a run-length reference model.
`timescale 1ns/1ps

module tb_key_debounce;

    localparam int STABLE = 4;
    localparam int RDELAY = 8;
    localparam int RRATE  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       key_n = 1'b1;
    logic       key_level;
    logic       press;
    logic       release_pulse;
    logic [7:0] press_count;

    int checks = 0;
    int failures = 0;

    key_debounce #(
        .STABLE_SAMPLES(STABLE),
        .REPEAT_DELAY  (RDELAY),
        .REPEAT_RATE   (RRATE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .key_n        (key_n),
        .key_level    (key_level),
        .press        (press),
        .release_pulse(release_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted level flips after STABLE consecutive
    // disagreeing strobe samples; repeats follow the held-strobe count.
    logic       m_k1 = 1'b1, m_k2 = 1'b1, m_tp = 1'b1;
    logic       m_lvl = 1'b0, m_press = 1'b0, m_rel = 1'b0;
    logic       m_s, m_stb;
    int         m_run = 0, m_held = 0;
    logic [7:0] m_cnt = 8'd0;
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_k1 = 1'b1; m_k2 = 1'b1; m_tp = 1'b1;
            m_lvl = 1'b0; m_run = 0; m_held = 0;
            m_press = 1'b0; m_rel = 1'b0; m_cnt = 8'd0;
        end else begin
            m_s = ~m_k2;
            m_stb = tick_in & ~m_tp;
            m_press = 1'b0;
            m_rel = 1'b0;
            if (m_stb) begin
                if (m_s != m_lvl) begin
                    m_run++;
                    m_held = 0;
                    if (m_run == STABLE) begin
                        m_lvl = m_s;
                        m_run = 0;
                        if (m_s) m_press = 1'b1;
                        else m_rel = 1'b1;
                    end
                end else if (m_run > 0) begin
                    m_run = 0;
                end else if (m_lvl) begin
                    m_held++;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                    if (m_held >= RDELAY && (m_held - RDELAY) % RRATE == 0)
                        m_press = 1'b1;
`endif
                end
            end
            m_cnt = m_cnt + 8'(m_press);
            m_k2 = m_k1;
            m_k1 = key_n;
            m_tp = tick_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_press", int'(press), int'(m_press));
            check("model_release", int'(release_pulse), int'(m_rel));
            check("model_level", int'(key_level), int'(m_lvl));
            check("model_count", int'(press_count), int'(m_cnt));
        end
    end

    logic       o_press, o_rel, o_lvl;
    logic [7:0] o_cnt;

    task automatic cap();
        o_press = press;
        o_rel   = release_pulse;
        o_lvl   = key_level;
        o_cnt   = press_count;
    endtask

    task automatic chk_outs(input string tag, input logic pr, input logic rl,
                            input logic lv, input logic [7:0] cnt);
        check({tag, "_press"}, int'(o_press), int'(pr));
        check({tag, "_release"}, int'(o_rel), int'(rl));
        check({tag, "_level"}, int'(o_lvl), int'(lv));
        check({tag, "_count"}, int'(o_cnt), int'(cnt));
    endtask

    // One strobe every 16 clk; the sample is settled well before the edge.
    task automatic strobe(input logic p);
        @(negedge clk);
        key_n = ~p;
        tick_in = 1'b0;
        repeat (8) @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        cap();
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cap();
    endtask

    typedef struct packed {
        logic       p;
        logic       e_press;
        logic       e_rel;
        logic       e_lvl;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic p, input logic pr, input logic rl,
                                input logic lv, input logic [7:0] c,
                                input int n = 1);
        repeat (n) tbl.push_back({p, pr, rl, lv, c});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_press;
        int div;
        int bouncy;
        logic exp_rep;

        // clean press, clean release
        add(1, 0, 0, 0, 8'd0, 3);
        add(1, 1, 0, 1, 8'd1);
        add(0, 0, 0, 1, 8'd1, 3);
        add(0, 0, 1, 0, 8'd1);
        // bounce: 1,1,0,1,1,1,1
        add(1, 0, 0, 0, 8'd1, 2);
        add(0, 0, 0, 0, 8'd1);
        add(1, 0, 0, 0, 8'd1, 3);
        add(1, 1, 0, 1, 8'd2);
        // release glitch 0,0,1 then a clean release
        add(0, 0, 0, 1, 8'd2, 2);
        add(1, 0, 0, 1, 8'd2);
        add(0, 0, 0, 1, 8'd2, 3);
        add(0, 0, 1, 0, 8'd2);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        cap();
        chk_outs("reset", 0, 0, 0, 8'd0);

        foreach (tbl[i]) begin
            strobe(tbl[i].p);
            chk_outs($sformatf("vec%0d", i), tbl[i].e_press, tbl[i].e_rel,
                     tbl[i].e_lvl, tbl[i].e_cnt);
        end

        // reset in PRESS_WAIT with three samples counted
        repeat (3) strobe(1'b1);
        pulse_rst();
        chk_outs("rst_mid", 0, 0, 0, 8'd0);
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1);
            chk_outs($sformatf("rst_fresh%0d", i), (i == 3), 0, (i == 3),
                     (i == 3) ? 8'd1 : 8'd0);
        end
        for (int i = 0; i < 4; i++) begin
            strobe(1'b0);
            chk_outs($sformatf("rst_rel%0d", i), 0, (i == 3), (i != 3), 8'd1);
        end

        // auto-repeat: hold for 16 strobes after acceptance
        pulse_rst();
        repeat (3) strobe(1'b1);
        strobe(1'b1);
        chk_outs("rep_accept", 1, 0, 1, 8'd1);
        n_press = 0;
        for (int j = 1; j <= 16; j++) begin
            strobe(1'b1);
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            exp_rep = (j >= 8) && ((j - 8) % 2 == 0);
`else
            exp_rep = 1'b0;
`endif
            check($sformatf("rep_strobe%0d", j), int'(o_press), int'(exp_rep));
            n_press += int'(o_press);
        end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        check("rep_count", int'(o_cnt), 6);
        check("rep_pulses", n_press, 5);
`else
        check("rep_count", int'(o_cnt), 1);
        check("rep_pulses", n_press, 0);
`endif
        repeat (4) strobe(1'b0);
        check("rep_released", int'(o_lvl), 0);

        // wrap: 256 clean press/release cycles from zero
        pulse_rst();
        n_press = 0;
        for (int k = 0; k < 256; k++) begin
            for (int i = 0; i < 4; i++) begin
                strobe(1'b1);
                n_press += int'(o_press);
            end
            if (k == 254) check("wrap_255", int'(o_cnt), 255);
            for (int i = 0; i < 4; i++) strobe(1'b0);
        end
        check("wrap_count", int'(o_cnt), 0);
        check("wrap_pulses", n_press, 256);

        // random phase: free-running divider, calm and bouncy key phases
        div = 0;
        bouncy = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            div++;
            tick_in = (div % 16) >= 8;
            if (c % 600 == 0) bouncy = $urandom_range(0, 1);
            if (bouncy != 0) begin
                if ($urandom_range(0, 99) < 25) key_n = ~key_n;
            end else begin
                if ($urandom_range(0, 999) < 3) key_n = ~key_n;
            end
            rst = ($urandom_range(0, 4999) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
